// File: rtl/pe_array_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_array_layer_sequencer_if
// Groups the layer-config / start inputs, the writeback handshake and the
// PE-array control strobes of the layer sequencer into one bundle.
//   slave  : sequencer side (takes start/cfg/out_ready, drives strobes)
//   master : config + writeback side (drives start/cfg/out_ready)
// Parameter CNT_W: width of cfg_acc_cycles / cfg_num_outputs.
// ---------------------------------------------------------------------------
interface pe_array_layer_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] cfg_acc_cycles;
  logic [CNT_W-1:0] cfg_num_outputs;
  logic [1:0]       cfg_output_precision;
  logic             cfg_load_bias;
  logic             out_ready;
  logic             busy;
  logic             enable_array;
  logic             clear;
  logic             enable_input_fifo;
  logic             enable_bias_32bits;
  logic [1:0]       addr_bias_32bits;
  logic             enable_BUFFERED_OUTPUT;
  logic             out_valid;
  logic             out_last;
  logic             done_layer;

  modport slave (
    input  start, cfg_acc_cycles, cfg_num_outputs, cfg_output_precision,
           cfg_load_bias, out_ready,
    output busy, enable_array, clear, enable_input_fifo, enable_bias_32bits,
           addr_bias_32bits, enable_BUFFERED_OUTPUT, out_valid, out_last,
           done_layer
  );

  modport master (
    output start, cfg_acc_cycles, cfg_num_outputs, cfg_output_precision,
           cfg_load_bias, out_ready,
    input  busy, enable_array, clear, enable_input_fifo, enable_bias_32bits,
           addr_bias_32bits, enable_BUFFERED_OUTPUT, out_valid, out_last,
           done_layer
  );
endinterface

// File: rtl/pe_array_layer_sequencer.sv
// ---------------------------------------------------------------------------
// pe_array_layer_sequencer
// Sequences one layer on the PE array: optional 4-beat bias load, then per
// output: clear MACs, accumulate cfg_acc_cycles cycles, capture into the
// packing buffers; after every group of 1/2/4 captures (by precision) or the
// final capture, the packed word is offered on out_valid/out_ready.
// Ports:
//   clk, reset (async, active-low)
//   sif (slave modport) : start/cfg_* in, out_ready in, busy, enable_array,
//                         clear, enable_input_fifo, enable_bias_32bits,
//                         addr_bias_32bits, enable_BUFFERED_OUTPUT,
//                         out_valid, out_last, done_layer out
// Optional feature macro PE_SEQ_PERF_CNT_EN adds:
//   perf_stall_cycles [CNT_W] : cycles in EMIT with out_ready low
//   perf_busy_cycles  [32]    : cycles with busy high
// All outputs are registered Moore decodes of the state register.
// ---------------------------------------------------------------------------
module pe_array_layer_sequencer #(
  parameter int CNT_W      = 16,
  parameter int BIAS_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  pe_array_layer_sequencer_if.slave    sif
`ifdef PE_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]             perf_stall_cycles,
  output logic [31:0]                  perf_busy_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIAS = 3'd1,
    S_CLR  = 3'd2,
    S_ACC  = 3'd3,
    S_CAP  = 3'd4,
    S_EMIT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [1:0]       BIAS_LAST = 2'(BIAS_BYTES - 1);

  // Strobe vector: {busy, enable_array, clear, enable_input_fifo,
  //                 enable_bias_32bits, enable_BUFFERED_OUTPUT, out_valid, done_layer}
  function automatic logic [7:0] strobes_for(input state_t s);
    case (s)
      S_IDLE:  strobes_for = 8'b0000_0000;
      S_BIAS:  strobes_for = 8'b1100_1000;
      S_CLR:   strobes_for = 8'b1110_0000;
      S_ACC:   strobes_for = 8'b1101_0000;
      S_CAP:   strobes_for = 8'b1100_0100;
      S_EMIT:  strobes_for = 8'b1000_0010;  // array frozen while offering the word
      S_DONE:  strobes_for = 8'b1100_0001;
      default: strobes_for = 8'b0000_0000;
    endcase
  endfunction

  state_t           state_r;
  logic [7:0]       strobe_r;
  logic             out_last_r;
  logic [1:0]       bias_cnt_r;
  logic [CNT_W-1:0] acc_cnt_r;
  logic [CNT_W-1:0] acc_len_r;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] out_cnt_r;
  logic [2:0]       grp_cnt_r;
  logic [2:0]       grp_size_r;

  logic [CNT_W-1:0] out_cnt_inc_s;
  logic [2:0]       grp_cnt_inc_s;
  logic             start_acc_s;

  assign out_cnt_inc_s = out_cnt_r + CNT_ONE;
  assign grp_cnt_inc_s = grp_cnt_r + 3'd1;
  assign start_acc_s   = (state_r == S_IDLE) && sif.start;

  assign sif.busy                   = strobe_r[7];
  assign sif.enable_array           = strobe_r[6];
  assign sif.clear                  = strobe_r[5];
  assign sif.enable_input_fifo      = strobe_r[4];
  assign sif.enable_bias_32bits     = strobe_r[3];
  assign sif.enable_BUFFERED_OUTPUT = strobe_r[2];
  assign sif.out_valid              = strobe_r[1];
  assign sif.done_layer             = strobe_r[0];
  assign sif.out_last               = out_last_r;
  // bias_cnt_r returns to 0 on leaving BIAS, so the address idles at 0
  assign sif.addr_bias_32bits       = bias_cnt_r;

  // Layer FSM: state, counters, latched config and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      strobe_r   <= 8'b0000_0000;
      out_last_r <= 1'b0;
      bias_cnt_r <= 2'd0;
      acc_cnt_r  <= CNT_ZERO;
      acc_len_r  <= CNT_ZERO;
      num_r      <= CNT_ZERO;
      out_cnt_r  <= CNT_ZERO;
      grp_cnt_r  <= 3'd0;
      grp_size_r <= 3'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (sif.start) begin
            acc_len_r  <= (sif.cfg_acc_cycles == CNT_ZERO) ? CNT_ONE : sif.cfg_acc_cycles;
            num_r      <= sif.cfg_num_outputs;
            case (sif.cfg_output_precision)
              2'd1:    grp_size_r <= 3'd2;
              2'd2:    grp_size_r <= 3'd4;
              default: grp_size_r <= 3'd1;
            endcase
            out_cnt_r  <= CNT_ZERO;
            grp_cnt_r  <= 3'd0;
            bias_cnt_r <= 2'd0;
            if (sif.cfg_num_outputs == CNT_ZERO) begin
              state_r  <= S_DONE;
              strobe_r <= strobes_for(S_DONE);
            end else if (sif.cfg_load_bias) begin
              state_r  <= S_BIAS;
              strobe_r <= strobes_for(S_BIAS);
            end else begin
              state_r  <= S_CLR;
              strobe_r <= strobes_for(S_CLR);
            end
          end
        end
        S_BIAS: begin
          bias_cnt_r <= bias_cnt_r + 2'd1;
          if (bias_cnt_r == BIAS_LAST) begin
            state_r  <= S_CLR;
            strobe_r <= strobes_for(S_CLR);
          end
        end
        S_CLR: begin
          acc_cnt_r <= CNT_ONE;
          state_r   <= S_ACC;
          strobe_r  <= strobes_for(S_ACC);
        end
        S_ACC: begin
          if (acc_cnt_r == acc_len_r) begin
            state_r  <= S_CAP;
            strobe_r <= strobes_for(S_CAP);
          end else begin
            acc_cnt_r <= acc_cnt_r + CNT_ONE;
          end
        end
        S_CAP: begin
          out_cnt_r <= out_cnt_inc_s;
          grp_cnt_r <= grp_cnt_inc_s;
          if ((grp_cnt_inc_s == grp_size_r) || (out_cnt_inc_s == num_r)) begin
            out_last_r <= (out_cnt_inc_s == num_r);
            state_r    <= S_EMIT;
            strobe_r   <= strobes_for(S_EMIT);
          end else begin
            state_r    <= S_CLR;
            strobe_r   <= strobes_for(S_CLR);
          end
        end
        S_EMIT: begin
          if (sif.out_ready) begin
            grp_cnt_r  <= 3'd0;
            out_last_r <= 1'b0;
            if (out_cnt_r != num_r) begin
              state_r  <= S_CLR;
              strobe_r <= strobes_for(S_CLR);
            end else begin
              state_r  <= S_DONE;
              strobe_r <= strobes_for(S_DONE);
            end
          end
        end
        S_DONE: begin
          state_r  <= S_IDLE;
          strobe_r <= strobes_for(S_IDLE);
        end
        default: begin
          state_r    <= S_IDLE;
          strobe_r   <= 8'b0000_0000;
          out_last_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PE_SEQ_PERF_CNT_EN
  // Saturating performance counters, cleared on accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= CNT_ZERO;
      perf_busy_cycles  <= 32'd0;
    end else if (start_acc_s) begin
      perf_stall_cycles <= CNT_ZERO;
      perf_busy_cycles  <= 32'd0;
    end else begin
      if ((state_r == S_EMIT) && !sif.out_ready && (perf_stall_cycles != {CNT_W{1'b1}}))
        perf_stall_cycles <= perf_stall_cycles + CNT_ONE;
      if (strobe_r[7] && (perf_busy_cycles != 32'hFFFF_FFFF))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule
